if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined RISC toy core.
- Generates the PC and drives a variable-latency instruction-memory request/acknowledge handshake.
- Delivers fetched instructions through the IF/ID register; instr_out[31:27] is the opcode field consumed by the main control decoder.
- Accepts stall from hazard logic and redirect (branch/jump target) from later stages; inserts NOP bubbles that decode to no architectural side effects.

---
 rtl/if_fetch_unit_pkg.sv | 21 ++
 rtl/if_fetch_unit_hold_buffer.sv | 55 +++++
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'hF800_0000;
    localparam int unsigned OPCODE_MSB     = 31;
    localparam int unsigned OPCODE_LSB     = 27;
    localparam int unsigned OPCODE_W       = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned PC_INC_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_HOLD = 2'd2,
        DROP      = 2'd3
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/if_fetch_unit_hold_buffer.sv
// One-entry skid register holding a fetched instruction and its PC while ID stalls.
module if_hold_buffer
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    logic              full_q, full_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Clear wins over load, load wins over unload.
    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full  = full_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, imem req/ack handshake, IF/ID register,
// stall skid buffering and redirect flush with stale-response dropping.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = PC_INC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              valid_q, valid_d;

    logic              hold_load, hold_unload, hold_clear, hold_full;
    logic [31:0]       hold_instr;
    logic [ADDR_W-1:0] hold_pc;
    logic              ack_seen;

    assign ack_seen = imem_ack && req_q;

    if_hold_buffer #(.ADDR_W(ADDR_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .unload   (hold_unload),
        .clear    (hold_clear),
        .instr_in (imem_rdata),
        .pc_in    (addr_q),
        .full     (hold_full),
        .instr    (hold_instr),
        .pc       (hold_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        hold_clear  = 1'b0;

        // ID consumes the current entry whenever it is not stalled.
        if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ack_seen ? REQ : DROP;
                end else if (ack_seen) begin
                    pc_d = pc_q + ADDR_W'(PC_INC);
                    if (!stall || !valid_q) begin
                        instr_d  = imem_rdata;
                        pc_out_d = addr_q;
                        valid_d  = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = WAIT_HOLD;
                    end
                end
            end
            WAIT_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (!stall && hold_full) begin
                    instr_d     = hold_instr;
                    pc_out_d    = hold_pc;
                    valid_d     = 1'b1;
                    hold_unload = 1'b1;
                    state_d     = REQ;
                end
            end
            DROP: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (ack_seen) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // Redirect flushes IF/ID and the skid entry regardless of state.
        if (redirect_valid) begin
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            hold_clear = 1'b1;
        end

        req_d  = (state_d == REQ) || (state_d == DROP);
        addr_d = (state_d == REQ) ? pc_d : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with hand-computed expectations.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                                input logic a, input logic [31:0] rd, input logic ereq,
                                input logic [31:0] eaddr, input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.ack = a; v.rdata = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.einstr = ei; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Drive inputs away from the rising edge.
    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                         input logic a, input logic [31:0] rd);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc; imem_ack = a; imem_rdata = rd;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, " imem_req"},    32'(imem_req),    32'(ereq));
        chk({tag, " imem_addr"},   imem_addr,        eaddr);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(ev));
        chk({tag, " instr_out"},   instr_out,        ei);
        chk({tag, " pc_out"},      pc_out,           ep);
    endtask

    localparam logic [31:0] N = NOP_INSTR;

    initial begin
        logic [31:0] op_word;

        // Each row: inputs for this cycle, and the registered outputs visible during it.
        // zero-wait fetch of 0,4,8
        vecs.push_back(mk(1,0,0,0,0,0,                      0,32'h00,0,N,0));
        vecs.push_back(mk(0,0,0,0,0,0,                      0,32'h00,0,N,0));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0001,          1,32'h00,0,N,0));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0002,          1,32'h04,1,32'h0800_0001,32'h00));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0003,          1,32'h08,1,32'h0800_0002,32'h04));
        // 3-cycle ack latency at 0xC
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h0C,1,32'h0800_0003,32'h08));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h0C,0,N,32'h08));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0004,          1,32'h0C,0,N,32'h08));
        // 4-cycle stall while the 0x10 fetch acks
        vecs.push_back(mk(0,1,0,0,1,32'h0800_0005,          1,32'h10,1,32'h0800_0004,32'h0C));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h10,1,32'h0800_0004,32'h0C));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h10,1,32'h0800_0004,32'h0C));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h10,1,32'h0800_0004,32'h0C));
        vecs.push_back(mk(0,0,0,0,0,0,                      0,32'h10,1,32'h0800_0004,32'h0C));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0006,          1,32'h14,1,32'h0800_0005,32'h10));
        // redirect to 0x40 mid-request, stale ack dropped
        vecs.push_back(mk(0,0,1,32'h40,0,0,                 1,32'h18,1,32'h0800_0006,32'h14));
        vecs.push_back(mk(0,0,0,0,1,32'hDEAD_BEEF,          1,32'h18,0,N,32'h14));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0040,          1,32'h40,0,N,32'h14));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h44,1,32'h0800_0040,32'h40));
        // fill hold buffer under stall, then redirect+stall flushes it
        vecs.push_back(mk(0,1,0,0,1,32'h0800_0044,          1,32'h44,0,N,32'h40));
        vecs.push_back(mk(0,1,0,0,1,32'h0800_0048,          1,32'h48,1,32'h0800_0044,32'h44));
        vecs.push_back(mk(0,1,1,32'h80,0,0,                 0,32'h48,1,32'h0800_0044,32'h44));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_0080,          1,32'h80,0,N,32'h44));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h84,1,32'h0800_0080,32'h80));
        // redirect with same-cycle ack, then PC wrap
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,1,32'h1234_5678, 1,32'h84,0,N,32'h80));
        vecs.push_back(mk(0,0,0,0,1,32'h0800_00FF,          1,32'hFFFF_FFFC,0,N,32'h80));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h00,1,32'h0800_00FF,32'hFFFF_FFFC));
        // reset during an outstanding request
        vecs.push_back(mk(1,0,0,0,0,0,                      1,32'h00,0,N,32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,0,0,0,0,                      0,32'h00,0,N,32'h00));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h00,0,N,32'h00));

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
            chk_all($sformatf("row%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid,
                    vecs[i].einstr, vecs[i].epc);
        end

        // Redirect while already dropping: only the latest target is fetched.
        drive(0, 0, 1, 32'h100, 0, 0);
        chk_all("drop_a", 1, 32'h00, 0, N, 32'h00);
        drive(0, 0, 1, 32'h200, 0, 0);
        chk_all("drop_b", 1, 32'h00, 0, N, 32'h00);
        drive(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        chk_all("drop_c", 1, 32'h00, 0, N, 32'h00);
        drive(0, 0, 0, 0, 1, 32'h0800_0200);
        chk_all("drop_d", 1, 32'h200, 0, N, 32'h00);
        drive(0, 0, 0, 0, 0, 0);
        chk_all("drop_e", 1, 32'h204, 1, 32'h0800_0200, 32'h200);
        op_word = instr_out;
        chk("drop_e opcode", 32'(opcode_of(op_word)), 32'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
